rainbow_light_ctrl: RTL



---
 rtl/rainbow_light_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rainbow_light_ctrl.sv
// Parametrised rainbow LED pattern generator: FILL, ALT, BOUNCE and OFF patterns stepped by a clock prescaler.
// Optional macro RAINBOW_DWELL_EN holds the all-on FILL state for DWELL extra ticks.
module rainbow_light_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4,
    parameter int DWELL = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] dout,
    output logic             step,
    output logic             wrap
);
    typedef enum logic [1:0] {FILL = 2'd0, ALT = 2'd1, BOUNCE = 2'd2, OFF = 2'd3} mode_t;

    localparam int PW = $clog2(2 * WIDTH);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] IDLE = PW'(2 * WIDTH - 1);
    localparam logic [PW-1:0] TOP  = PW'(WIDTH - 1);
    localparam logic [CW-1:0] CMAX = CW'(DIV - 1);

    function automatic logic [WIDTH-1:0] fill_pat(input logic [PW-1:0] p);
        logic [WIDTH-1:0] ones;
        ones = '1;
        if (p < PW'(WIDTH)) return ones >> (TOP - p);
        else                return ones << (p - TOP);
    endfunction

    function automatic logic [WIDTH-1:0] alt_pat(input logic odd);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = odd ? (i % 2 == 1) : (i % 2 == 0);
        return r;
    endfunction

    mode_t            cur, mode_q;
    logic             mode_vld;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [PW-1:0]    p_q, p_n;
    logic             dir_q, dir_n;
    logic [WIDTH-1:0] dout_n;
    logic             step_n, wrap_n;
    logic             mode_chg, tick, hold;

    assign cur      = mode_t'(mode);
    assign mode_chg = mode_vld && (cur != mode_q);
    assign tick     = en && (cnt_q == CMAX);

`ifdef RAINBOW_DWELL_EN
    localparam int DWW = $clog2(DWELL + 2);
    logic [DWW-1:0] dwell_q, dwell_n;

    assign hold = (cur == FILL) && (p_q == TOP) && (dwell_q < DWW'(DWELL));

    always_comb begin
        dwell_n = dwell_q;
        if (mode_chg)                  dwell_n = '0;
        else if (tick && cur == FILL)  dwell_n = hold ? dwell_q + DWW'(1) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dwell_q <= '0;
        else        dwell_q <= dwell_n;
    end
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        cnt_n  = cnt_q;
        p_n    = p_q;
        dir_n  = dir_q;
        dout_n = dout;
        step_n = 1'b0;
        wrap_n = 1'b0;
        if (mode_chg) begin
            // A mode change restarts the new pattern from idle and suppresses any coincident tick.
            cnt_n  = '0;
            p_n    = IDLE;
            dir_n  = 1'b1;
            dout_n = '0;
        end else if (en) begin
            cnt_n = tick ? '0 : cnt_q + CW'(1);
            if (tick) begin
                case (cur)
                    FILL: begin
                        if (!hold) begin
                            p_n    = (p_q == IDLE) ? '0 : p_q + PW'(1);
                            dout_n = fill_pat(p_n);
                            step_n = 1'b1;
                            wrap_n = (p_n == IDLE);
                        end
                    end
                    ALT: begin
                        p_n    = (p_q == '0) ? PW'(1) : '0;
                        dout_n = alt_pat(p_n[0]);
                        step_n = 1'b1;
                        wrap_n = (p_n == PW'(1));
                    end
                    BOUNCE: begin
                        if (p_q >= PW'(WIDTH)) begin
                            p_n   = '0;
                            dir_n = 1'b1;
                        end else if (dir_q) begin
                            p_n = p_q + PW'(1);
                            if (p_n == TOP) dir_n = 1'b0;
                        end else begin
                            p_n = p_q - PW'(1);
                            if (p_n == '0) begin
                                dir_n  = 1'b1;
                                wrap_n = 1'b1;
                            end
                        end
                        dout_n = WIDTH'(1) << p_n;
                        step_n = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= FILL;
            mode_vld <= 1'b0;
            cnt_q    <= '0;
            p_q      <= IDLE;
            dir_q    <= 1'b1;
            dout     <= '0;
            step     <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            mode_q   <= cur;
            mode_vld <= 1'b1;
            cnt_q    <= cnt_n;
            p_q      <= p_n;
            dir_q    <= dir_n;
            dout     <= dout_n;
            step     <= step_n;
            wrap     <= wrap_n;
        end
    end
endmodule
